duty_soft_start: RTL and testbench

Duty-cycle soft-start and slew-limit stage that sits directly upstream of the DPWM and drives its `adjDutyCycle` input. It takes the nominal duty count from the duty converter and the period count `maxcount` from the frequency converter. It releases the duty to the DPWM only on PWM period boundaries:

- ramps up from zero after enable when soft start is requested;
- slew-limits later increases;
- applies decreases immediately.

It runs a period counter identical to the DPWM's, so updates land at the DPWM's counter wrap.

---
 rtl/duty_soft_start.sv | 223 ++++++++++++++++++++++
 tb/tb_duty_soft_start.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/duty_soft_start.sv
// -----------------------------------------------------------------------------
// duty_soft_start
//
// Soft-start / slew-limit stage placed in front of the DPWM. It runs a period
// counter that matches the DPWM's own counter, so that every duty update lands
// on the DPWM's counter wrap. After enable the duty either ramps up from zero
// (soft start) or jumps straight to the target. Later increases are
// slew-limited, and decreases are applied at the next period boundary.
//
// Ports:
//   clk          system clock, single domain
//   resetn       asynchronous active-low reset
//   EN           converter enable; low forces the shutdown (IDLE) state
//   soft_start   ramp request, only looked at when leaving IDLE
//   maxcount     PWM period count (period = maxcount + 1 clocks)
//   duty_target  nominal duty count from the duty converter
//   adj_duty     registered duty count handed to the DPWM
//   period_tick  registered one-cycle strobe at each period wrap
//   ramp_done    registered; high while settled at the saturated target
// -----------------------------------------------------------------------------
module duty_soft_start #(
    parameter int W            = 10,
    parameter int STEP_PERIODS = 4,
    parameter int STEP_SIZE    = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         EN,
    input  logic         soft_start,
    input  logic [W-1:0] maxcount,
    input  logic [W-1:0] duty_target,
    output logic [W-1:0] adj_duty,
    output logic         period_tick,
    output logic         ramp_done
);

    // A divider for one period per step still needs a 1-bit register.
    localparam int DW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    localparam logic [W-1:0]  ONE_W    = W'(1);
    localparam logic [W-1:0]  ZERO_W   = W'(0);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [DW-1:0] DIV_ZERO = DW'(0);
    localparam logic [DW-1:0] DIV_LAST = DW'(STEP_PERIODS - 1);
    localparam logic [W:0]    STEP_W   = (W + 1)'(STEP_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [W-1:0]  pcnt_r;
    logic [W-1:0]  pcnt_nxt_s;
    logic          tick_s;
    logic [DW-1:0] divcnt_r;
    logic [DW-1:0] divcnt_nxt_s;
    logic [W-1:0]  adj_duty_r;
    logic [W-1:0]  adj_duty_nxt_s;
    logic          ramp_done_r;
    logic          ramp_done_nxt_s;
    logic          period_tick_r;
    logic [W-1:0]  tgt_sat_s;
    logic [W:0]    step_sum_s;
    logic [W-1:0]  step_val_s;
    logic          div_last_s;

    // Saturated target, and one ramp step taken one bit wider so it cannot wrap.
    always_comb begin
        if (duty_target < maxcount) begin
            tgt_sat_s = duty_target;
        end else begin
            tgt_sat_s = maxcount;
        end
        step_sum_s = {1'b0, adj_duty_r} + STEP_W;
        if (step_sum_s > {1'b0, tgt_sat_s}) begin
            step_val_s = tgt_sat_s;
        end else begin
            step_val_s = step_sum_s[W-1:0];
        end
        div_last_s = (divcnt_r == DIV_LAST);
    end

    // Period counter; a counter above a freshly reduced maxcount wraps at once.
    always_comb begin
        tick_s     = 1'b0;
        pcnt_nxt_s = ZERO_W;
        if (!EN) begin
            pcnt_nxt_s = ZERO_W;
        end else if (pcnt_r < maxcount) begin
            pcnt_nxt_s = pcnt_r + ONE_W;
        end else begin
            pcnt_nxt_s = ZERO_W;
            tick_s     = 1'b1;
        end
    end

    // State register and period counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            pcnt_r  <= ZERO_W;
        end else begin
            state_r <= state_nxt_s;
            pcnt_r  <= pcnt_nxt_s;
        end
    end

    // Next-state decision, taken only on a period wrap; EN low overrides all.
    always_comb begin
        state_nxt_s = state_r;
        if (!EN) begin
            state_nxt_s = ST_IDLE;
        end else if (tick_s) begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = soft_start ? ST_RAMP : ST_HOLD;
                end
                ST_RAMP: begin
                    if (tgt_sat_s < adj_duty_r) begin
                        state_nxt_s = ST_HOLD;
                    end else if (div_last_s && (step_val_s == tgt_sat_s)) begin
                        state_nxt_s = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_RAMP;
                    end
                end
                ST_HOLD: begin
                    if (tgt_sat_s > adj_duty_r) begin
                        state_nxt_s = ST_RAMP;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Next values of duty, done flag and ramp divider.
    always_comb begin
        adj_duty_nxt_s  = adj_duty_r;
        ramp_done_nxt_s = ramp_done_r;
        divcnt_nxt_s    = divcnt_r;
        if (!EN) begin
            adj_duty_nxt_s  = ZERO_W;
            ramp_done_nxt_s = 1'b0;
            divcnt_nxt_s    = DIV_ZERO;
        end else if (tick_s) begin
            case (state_r)
                ST_IDLE: begin
                    divcnt_nxt_s = DIV_ZERO;
                    if (soft_start) begin
                        adj_duty_nxt_s  = ZERO_W;
                        ramp_done_nxt_s = 1'b0;
                    end else begin
                        adj_duty_nxt_s  = tgt_sat_s;
                        ramp_done_nxt_s = 1'b1;
                    end
                end
                ST_RAMP: begin
                    if (tgt_sat_s < adj_duty_r) begin
                        // Target fell below the ramp: drop straight to it.
                        adj_duty_nxt_s  = tgt_sat_s;
                        ramp_done_nxt_s = 1'b1;
                        divcnt_nxt_s    = DIV_ZERO;
                    end else if (div_last_s) begin
                        adj_duty_nxt_s  = step_val_s;
                        ramp_done_nxt_s = (step_val_s == tgt_sat_s);
                        divcnt_nxt_s    = DIV_ZERO;
                    end else begin
                        divcnt_nxt_s    = divcnt_r + DIV_ONE;
                    end
                end
                ST_HOLD: begin
                    if (tgt_sat_s < adj_duty_r) begin
                        adj_duty_nxt_s  = tgt_sat_s;
                        ramp_done_nxt_s = 1'b1;
                    end else if (tgt_sat_s > adj_duty_r) begin
                        // Re-enter the ramp; the first step waits a full divider cycle.
                        ramp_done_nxt_s = 1'b0;
                        divcnt_nxt_s    = DIV_ZERO;
                    end else begin
                        adj_duty_nxt_s  = adj_duty_r;
                    end
                end
                default: begin
                    adj_duty_nxt_s  = ZERO_W;
                    ramp_done_nxt_s = 1'b0;
                    divcnt_nxt_s    = DIV_ZERO;
                end
            endcase
        end else begin
            adj_duty_nxt_s = adj_duty_r;
        end
    end

    // Output and divider registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            adj_duty_r    <= ZERO_W;
            ramp_done_r   <= 1'b0;
            divcnt_r      <= DIV_ZERO;
            period_tick_r <= 1'b0;
        end else begin
            adj_duty_r    <= adj_duty_nxt_s;
            ramp_done_r   <= ramp_done_nxt_s;
            divcnt_r      <= divcnt_nxt_s;
            period_tick_r <= tick_s;
        end
    end

    assign adj_duty    = adj_duty_r;
    assign ramp_done   = ramp_done_r;
    assign period_tick = period_tick_r;

endmodule

// File: tb/tb_duty_soft_start.sv
// -----------------------------------------------------------------------------
// Testbench for duty_soft_start (STEP_PERIODS=2, STEP_SIZE=2, W=10).
// A period-level reference model tracks the expected outputs every clock;
// directed scenarios add fixed expectations at the interesting ticks, and a
// randomized phase exercises enable, target and period changes.
// -----------------------------------------------------------------------------
module tb_duty_soft_start;

    localparam int SP = 2;
    localparam int SS = 2;

    logic       clk;
    logic       resetn;
    logic       EN;
    logic       soft_start;
    logic [9:0] maxcount;
    logic [9:0] duty_target;
    logic [9:0] adj_duty;
    logic       period_tick;
    logic       ramp_done;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_pcnt, m_mode, m_div, m_adj, m_done, m_tick;
    localparam int M_OFF = 0, M_RAMPING = 1, M_SETTLED = 2;

    duty_soft_start #(.W(10), .STEP_PERIODS(SP), .STEP_SIZE(SS)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .EN          (EN),
        .soft_start  (soft_start),
        .maxcount    (maxcount),
        .duty_target (duty_target),
        .adj_duty    (adj_duty),
        .period_tick (period_tick),
        .ramp_done   (ramp_done)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pcnt = 0; m_mode = M_OFF; m_div = 0; m_adj = 0; m_done = 0; m_tick = 0;
    endtask

    // One clock of the reference model, using the inputs present before the edge.
    task automatic model_edge();
        int mc, tgt, nxt;
        mc = int'(maxcount);
        tgt = (int'(duty_target) < mc) ? int'(duty_target) : mc;
        if (!resetn || !EN) begin
            model_reset();
        end else begin
            m_tick = (m_pcnt >= mc) ? 1 : 0;
            m_pcnt = m_tick ? 0 : m_pcnt + 1;
            if (m_tick == 1) begin
                if (m_mode == M_OFF) begin
                    m_div = 0;
                    if (soft_start) begin m_mode = M_RAMPING; m_adj = 0; m_done = 0; end
                    else begin m_mode = M_SETTLED; m_adj = tgt; m_done = 1; end
                end else if (m_mode == M_RAMPING) begin
                    if (tgt < m_adj) begin
                        m_adj = tgt; m_mode = M_SETTLED; m_done = 1; m_div = 0;
                    end else if (m_div == SP - 1) begin
                        m_div = 0;
                        nxt = (m_adj + SS > tgt) ? tgt : m_adj + SS;
                        m_adj = nxt;
                        if (nxt == tgt) begin m_mode = M_SETTLED; m_done = 1; end
                    end else begin
                        m_div = m_div + 1;
                    end
                end else begin
                    if (tgt < m_adj) begin m_adj = tgt; m_done = 1; end
                    else if (tgt > m_adj) begin m_mode = M_RAMPING; m_done = 0; m_div = 0; end
                end
            end
        end
    endtask

    // Advance one clock and compare all outputs against the model.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("adj_duty", 32'(adj_duty), 32'(m_adj));
        chk("period_tick", 32'(period_tick), 32'(m_tick));
        chk("ramp_done", 32'(ramp_done), 32'(m_done));
    endtask

    // Step until n ticks are seen (bounded); returns the clocks taken.
    task automatic run_ticks(input int n, output int cyc);
        int seen;
        seen = 0;
        cyc = 0;
        while (seen < n && cyc < 400) begin
            step();
            cyc++;
            if (period_tick === 1'b1) seen++;
        end
        chk("tick_budget", 32'(seen), 32'(n));
    endtask

    task automatic wait_pcnt(input int v);
        int guard;
        guard = 0;
        while (m_pcnt != v && guard < 100) begin
            step();
            guard++;
        end
        chk("pcnt_reached", 32'(m_pcnt), 32'(v));
    endtask

    initial begin
        int c;
        resetn = 1'b1; EN = 1'b0; soft_start = 1'b0;
        maxcount = 10'd9; duty_target = 10'd5;
        model_reset();
        #3 resetn = 1'b0;
        #1;
        chk("reset_adj", 32'(adj_duty), 32'd0);
        chk("reset_tick", 32'(period_tick), 32'd0);
        chk("reset_done", 32'(ramp_done), 32'd0);
        step(); step();
        #4 resetn = 1'b1;
        step();

        // soft-start ramp 0 -> 2 -> 4 -> 5
        soft_start = 1'b1; EN = 1'b1;
        run_ticks(1, c);  chk("first_tick_lat", 32'(c), 32'd10);
        run_ticks(2, c);  chk("ramp_t3", 32'(adj_duty), 32'd2);
        chk("period_len", 32'(c), 32'd20);
        run_ticks(2, c);  chk("ramp_t5", 32'(adj_duty), 32'd4);
        chk("ramp_t5_done", 32'(ramp_done), 32'd0);
        run_ticks(2, c);  chk("ramp_t7", 32'(adj_duty), 32'd5);
        chk("ramp_t7_done", 32'(ramp_done), 32'd1);

        // saturation at maxcount, then immediate decrease
        duty_target = 10'd20;
        run_ticks(1, c);  chk("sat_enter", 32'(adj_duty), 32'd5);
        chk("sat_done_clr", 32'(ramp_done), 32'd0);
        run_ticks(2, c);  chk("sat_7", 32'(adj_duty), 32'd7);
        run_ticks(2, c);  chk("sat_9", 32'(adj_duty), 32'd9);
        chk("sat_done", 32'(ramp_done), 32'd1);
        run_ticks(2, c);  chk("sat_hold", 32'(adj_duty), 32'd9);
        duty_target = 10'd3;
        run_ticks(1, c);  chk("drop_3", 32'(adj_duty), 32'd3);

        // direct start
        EN = 1'b0; step();
        soft_start = 1'b0; duty_target = 10'd6; EN = 1'b1;
        run_ticks(1, c);  chk("direct_lat", 32'(c), 32'd10);
        chk("direct_adj", 32'(adj_duty), 32'd6);
        chk("direct_done", 32'(ramp_done), 32'd1);

        // mid-ramp disable and restart
        EN = 1'b0; step();
        soft_start = 1'b1; duty_target = 10'd5; EN = 1'b1;
        run_ticks(5, c);  chk("pre_dis_adj", 32'(adj_duty), 32'd4);
        EN = 1'b0; step();
        chk("dis_adj", 32'(adj_duty), 32'd0);
        chk("dis_done", 32'(ramp_done), 32'd0);
        chk("dis_tick", 32'(period_tick), 32'd0);
        EN = 1'b1;
        run_ticks(1, c);  chk("restart_0", 32'(adj_duty), 32'd0);
        run_ticks(2, c);  chk("restart_2", 32'(adj_duty), 32'd2);

        // asynchronous reset between edges at pcnt=6
        wait_pcnt(6);
        #4 resetn = 1'b0;
        #1;
        chk("areset_adj", 32'(adj_duty), 32'd0);
        chk("areset_done", 32'(ramp_done), 32'd0);
        chk("areset_tick", 32'(period_tick), 32'd0);
        model_reset();
        step();
        #4 resetn = 1'b1;
        run_ticks(1, c);  chk("post_reset_lat", 32'(c), 32'd10);

        // maxcount shrink below the running counter
        wait_pcnt(7);
        maxcount = 10'd3;
        step();
        chk("shrink_tick", 32'(period_tick), 32'd1);
        run_ticks(3, c);  chk("shrink_period", 32'(c), 32'd12);
        chk("shrink_clamp", 32'(adj_duty <= 10'd3), 32'd1);

        // maxcount = 0: tick every clock, duty clamped to 0
        maxcount = 10'd0;
        step(); step(); step();
        chk("mc0_tick", 32'(period_tick), 32'd1);
        chk("mc0_adj", 32'(adj_duty), 32'd0);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) EN = ~EN;
            if ($urandom_range(0, 49) == 0) maxcount = 10'($urandom_range(0, 20));
            if ($urandom_range(0, 19) == 0) duty_target = 10'($urandom_range(0, 25));
            if ($urandom_range(0, 9) == 0) soft_start = 1'($urandom_range(0, 1));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
